// File: rtl/shift_seq_ctrl.sv
// Sequencer for the parallel-load / left-shift register: one load, WIDTH shifts, one done pulse per word.
// Optional build macro SHIFT_SEQ_CTRL_PAUSE_EN adds a pause input that freezes the SHIFT phase.
module shift_seq_ctrl #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             CLK,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             fill,
`ifdef SHIFT_SEQ_CTRL_PAUSE_EN
   input  logic             pause,
`endif
   output logic [WIDTH-1:0] I,
   output logic             load,
   output logic             shift,
   output logic             serial_in,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] shift_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT,
      ST_DONE
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] word_reg, word_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             hold;

`ifdef SHIFT_SEQ_CTRL_PAUSE_EN
   assign hold = pause;
`else
   assign hold = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (!reset_n) begin
         state_reg <= ST_IDLE;
         word_reg  <= '0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         word_reg  <= word_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      word_next  = word_reg;
      cnt_next   = cnt_reg;
      in_ready   = 1'b0;
      load       = 1'b0;
      shift      = 1'b0;
      serial_in  = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               word_next  = in_data;
               state_next = ST_LOAD;
            end
         end
         ST_LOAD: begin
            load       = 1'b1;
            busy       = 1'b1;
            cnt_next   = '0;
            state_next = ST_SHIFT;
         end
         ST_SHIFT: begin
            busy = 1'b1;
            // A paused cycle neither shifts nor counts; the word resumes where it stopped.
            if (!hold) begin
               shift     = 1'b1;
               serial_in = fill;
               cnt_next  = cnt_reg + 1'b1;
               if (cnt_reg == LAST_CNT) begin
                  state_next = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign I         = word_reg;
   assign shift_cnt = cnt_reg;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Randomised bench for shift_seq_ctrl: a timeline model of each word plus an attached shift register.
// Build with SHIFT_SEQ_CTRL_PAUSE_EN to exercise the pause input as well.
module tb_shift_seq_ctrl;
   localparam int W  = 4;
   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic          fill;
   logic [W-1:0]  I;
   logic          load, shift, serial_in, busy, done;
   logic [CW-1:0] shift_cnt;
`ifdef SHIFT_SEQ_CTRL_PAUSE_EN
   logic          pause_v;
`endif
   logic [W-1:0]  dut_q;

   int n_checks = 0;
   int n_errors = 0;

   // Model: t<0 idle, t==0 load cycle, t>=1 shifting (k shifts done) or done when k==W.
   int           t = -1;
   int           k = 0;
   int           m_cnt = 0;
   int           lat = 0;
   int           paused = 0;
   logic [W-1:0] m_i = '0;
   logic [W-1:0] m_fill = '0;

   always #5 clk = ~clk;

   shift_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
      .CLK       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .fill      (fill),
`ifdef SHIFT_SEQ_CTRL_PAUSE_EN
      .pause     (pause_v),
`endif
      .I         (I),
      .load      (load),
      .shift     (shift),
      .serial_in (serial_in),
      .busy      (busy),
      .done      (done),
      .shift_cnt (shift_cnt)
   );

   // The register this controller drives; its MSB is the serial output stream.
   always_ff @(posedge clk) begin
      if (load)
         dut_q <= I;
      else if (shift)
         dut_q <= {dut_q[W-2:0], serial_in};
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic cycle(input logic rn, input logic v, input logic [W-1:0] d, input logic f, input logic p);
      logic p_eff;
      logic e_shift, e_done;
`ifdef SHIFT_SEQ_CTRL_PAUSE_EN
      p_eff = p;
`else
      p_eff = 1'b0 & p;
`endif
      @(negedge clk);
      reset_n  = rn;
      in_valid = v;
      in_data  = d;
      fill     = f;
`ifdef SHIFT_SEQ_CTRL_PAUSE_EN
      pause_v  = p;
`endif
      #1;
      e_shift = (t >= 1) && (k < W) && !p_eff;
      e_done  = (t >= 1) && (k == W);
      check_val("in_ready",  32'(in_ready),  32'(t < 0));
      check_val("load",      32'(load),      32'(t == 0));
      check_val("shift",     32'(shift),     32'(e_shift));
      check_val("serial_in", 32'(serial_in), 32'(e_shift & f));
      check_val("busy",      32'(busy),      32'(t >= 0));
      check_val("done",      32'(done),      32'(e_done));
      check_val("I",         32'(I),         32'(m_i));
      check_val("shift_cnt", 32'(shift_cnt), 32'(m_cnt));
      if (e_shift)
         check_val("stream_bit", 32'(dut_q[W-1]), 32'(m_i[W-1-k]));
      if (e_done) begin
         check_val("q_final", 32'(dut_q), 32'(m_fill));
         check_val("latency", 32'(lat), 32'(W + 1 + paused));
      end
      $display("cyc rn=%0b v=%0b d=%h f=%0b p=%0b | rdy=%0b ld=%0b sh=%0b dn=%0b I=%h cnt=%0d q=%h",
               rn, v, d, f, p_eff, in_ready, load, shift, done, I, shift_cnt, dut_q);
      @(posedge clk);
      if (!rn) begin
         t = -1; k = 0; m_i = '0; m_cnt = 0;
      end else if (t < 0) begin
         if (v) begin
            m_i = d; t = 0; k = 0; m_fill = '0; lat = 0; paused = 0;
         end
      end else if (t == 0) begin
         t = 1; m_cnt = 0; lat++;
      end else if (k < W) begin
         lat++;
         if (p_eff) begin
            paused++;
         end else begin
            k++;
            m_cnt  = k;
            m_fill = {m_fill[W-2:0], f};
         end
      end else begin
         t = -1;
      end
   endtask

   initial begin
      reset_n  = 1'b0;
      in_valid = 1'b1;
      in_data  = 4'hF;
      fill     = 1'b0;
`ifdef SHIFT_SEQ_CTRL_PAUSE_EN
      pause_v  = 1'b0;
`endif
      repeat (2) @(posedge clk);

      // Reset held with a word offered: nothing may be accepted.
      repeat (2) cycle(1'b0, 1'b1, 4'hF, 1'b0, 1'b0);

      // Single word, fill 0.
      cycle(1'b1, 1'b1, 4'b1011, 1'b0, 1'b0);
      repeat (7) cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);

      // All-zero word with fill 1.
      cycle(1'b1, 1'b1, 4'b0000, 1'b1, 1'b0);
      repeat (7) cycle(1'b1, 1'b0, 4'h0, 1'b1, 1'b0);

      // Back-to-back with valid held; data changes while the first word shifts.
      repeat (3) cycle(1'b1, 1'b1, 4'b1010, 1'b0, 1'b0);
      repeat (12) cycle(1'b1, 1'b1, 4'b0101, 1'b1, 1'b0);
      repeat (8) cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);

      // Reset after the second shift, then a full word.
      cycle(1'b1, 1'b1, 4'b1100, 1'b1, 1'b0);
      repeat (3) cycle(1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 4'b0110, 1'b0, 1'b0);
      repeat (7) cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);

      // Pause for three cycles after the first shift (no effect without the pause build).
      cycle(1'b1, 1'b1, 4'b1011, 1'b0, 1'b0);
      repeat (2) cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
      repeat (3) cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
      repeat (8) cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);

      for (int n = 0; n < 600; n++) begin
         cycle(logic'($urandom_range(0, 49) != 0),
               logic'($urandom_range(0, 1)),
               W'($urandom),
               logic'($urandom_range(0, 1)),
               logic'($urandom_range(0, 3) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
